// File: rtl/zeroheti_pkg.sv
// Shared types for the debug SBA-to-OBI bridge: request/response records,
// transaction-ID width and the request-path FSM encoding.
package zeroheti_pkg;

  localparam int unsigned AidWidth     = 3;
  // Records are sized for the widest supported bus; narrower instances use the low bits.
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxDataWidth = 64;

  typedef logic [AidWidth-1:0] aid_t;

  typedef struct packed {
    logic [MaxAddrWidth-1:0]   addr;
    logic                      we;
    logic [MaxDataWidth/8-1:0] be;
    logic [MaxDataWidth-1:0]   wdata;
  } sba_req_t;

  typedef struct packed {
    logic                    valid;
    logic [MaxDataWidth-1:0] rdata;
    logic                    err;
    logic                    other_err;
  } sba_resp_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } req_state_e;

endpackage

// File: rtl/zeroheti_dbg_sba_idq.sv
// In-order FIFO of OBI transaction IDs awaiting a response.
module zeroheti_dbg_sba_idq
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  aid_t                data_i,
  input  logic                pop_i,
  output aid_t                head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  aid_t                mem [Depth];
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [CntWidth-1:0] count;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Storage, pointers and occupancy; callers never push when full or pop when empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (push_i) begin
        mem[wptr] <= data_i;
        wptr      <= ptr_next(wptr);
      end
      if (pop_i) rptr <= ptr_next(rptr);
      if (push_i && !pop_i)      count <= count + CntWidth'(1);
      else if (pop_i && !push_i) count <= count - CntWidth'(1);
    end
  end

  assign head_o  = mem[rptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == CntWidth'(Depth));
  assign count_o = count;

endmodule

// File: rtl/zeroheti_dbg_sba_bridge.sv
// Debug-module system-bus-access master to OBI bridge with in-order ID
// tracking. Optional response watchdog: define ZEROHETI_DBG_SBA_TIMEOUT_EN.
module zeroheti_dbg_sba_bridge
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sba_req_i,
  output logic                   sba_gnt_o,
  input  logic [AddrWidth-1:0]   sba_addr_i,
  input  logic                   sba_we_i,
  input  logic [DataWidth/8-1:0] sba_be_i,
  input  logic [DataWidth-1:0]   sba_wdata_i,
  output logic                   sba_rvalid_o,
  output logic [DataWidth-1:0]   sba_rdata_o,
  output logic                   sba_err_o,
  output logic                   sba_other_err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  output logic [AidWidth-1:0]    obi_aid_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic [AidWidth-1:0]    obi_rid_i,
  input  logic                   obi_err_i,
  output logic                   spurious_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeWidth  = DataWidth / 8;

  if (MaxOutstanding < 1 || MaxOutstanding > 8 || TimeoutCycles < 2 ||
      AddrWidth > MaxAddrWidth || DataWidth > MaxDataWidth || (DataWidth % 8) != 0) begin : g_param_check
    $error("zeroheti_dbg_sba_bridge: unsupported parameter set");
  end

  req_state_e          state_q, state_d;
  sba_req_t            req_q, req_d;
  sba_resp_t           resp_q, resp_d;
  aid_t                aid_q;
  aid_t                head;
  logic                empty;
  logic                idq_full;
  logic [CntWidth-1:0] live;
  logic [CntWidth-1:0] drop_cnt;
  logic [CntWidth:0]   occupancy;
  logic                room;
  logic                push;
  logic                pop;
  logic                accept;
  logic                drop_rsp;
  logic                spur_hit;
  logic                timeout;
  logic                spurious_q;
  logic                unused_pad;

  assign occupancy = {1'b0, live} + {1'b0, drop_cnt};
  assign room      = occupancy < (CntWidth + 1)'(MaxOutstanding);

  assign accept   = obi_rvalid_i && (drop_cnt == '0) && !empty;
  assign drop_rsp = obi_rvalid_i && (drop_cnt != '0);
  assign spur_hit = obi_rvalid_i && (drop_cnt == '0) && empty;
  assign pop      = accept || timeout;

  zeroheti_dbg_sba_idq #(
    .Depth    (MaxOutstanding),
    .CntWidth (CntWidth)
  ) u_idq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (aid_q),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (idq_full),
    .count_o (live)
  );

`ifdef ZEROHETI_DBG_SBA_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles);

  logic [WdWidth-1:0]  wd_q;
  logic [CntWidth-1:0] drop_q;

  assign timeout  = !obi_rvalid_i && (live != '0) && (wd_q == WdWidth'(TimeoutCycles - 1));
  assign drop_cnt = drop_q;

  // Watchdog: the grant cycle itself counts, so the timeout response lands
  // exactly TimeoutCycles cycles after the OBI grant.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                     wd_q <= '0;
    else if (obi_rvalid_i || (live == '0 && !push)) wd_q <= '0;
    else if (timeout)                              wd_q <= '0;
    else                                           wd_q <= wd_q + WdWidth'(1);
  end

  // Responses still owed for timed-out transactions; they are swallowed on arrival.
  always_ff @(posedge clk_i) begin
    if (rst_i)         drop_q <= '0;
    else if (timeout)  drop_q <= drop_q + CntWidth'(1);
    else if (drop_rsp) drop_q <= drop_q - CntWidth'(1);
  end
`else
  assign timeout  = 1'b0;
  assign drop_cnt = '0;
`endif

  // Request path: accept an SBA request into the register, then hold it on OBI until granted.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sba_gnt_o = 1'b0;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst_i && sba_req_i && room) begin
          sba_gnt_o                   = 1'b1;
          req_d                       = '0;
          req_d.addr[AddrWidth-1:0]   = sba_addr_i;
          req_d.we                    = sba_we_i;
          req_d.be[BeWidth-1:0]       = sba_be_i;
          req_d.wdata[DataWidth-1:0]  = sba_wdata_i;
          state_d                     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (obi_gnt_i) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response shaping: one-cycle pulse, data forced to zero when idle.
  always_comb begin
    resp_d = '0;
    if (accept) begin
      resp_d.valid                  = 1'b1;
      resp_d.rdata[DataWidth-1:0]   = obi_rdata_i;
      resp_d.err                    = obi_err_i;
      resp_d.other_err              = (obi_rid_i != head);
    end else if (timeout) begin
      resp_d.valid     = 1'b1;
      resp_d.other_err = 1'b1;
    end
  end

  // State, request/response registers, ID counter and sticky spurious flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      resp_q     <= '0;
      aid_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      if (push)     aid_q      <= aid_q + aid_t'(1);
      if (spur_hit) spurious_q <= 1'b1;
    end
  end

  assign obi_req_o       = (state_q == ST_ISSUE);
  assign obi_addr_o      = req_q.addr[AddrWidth-1:0];
  assign obi_we_o        = req_q.we;
  assign obi_be_o        = req_q.be[BeWidth-1:0];
  assign obi_wdata_o     = req_q.wdata[DataWidth-1:0];
  assign obi_aid_o       = aid_q;
  assign sba_rvalid_o    = resp_q.valid;
  assign sba_rdata_o     = resp_q.rdata[DataWidth-1:0];
  assign sba_err_o       = resp_q.err;
  assign sba_other_err_o = resp_q.other_err;
  assign spurious_o      = spurious_q;

  // Pad bits of the wide package records are never read.
  assign unused_pad = ^{req_q, resp_q, idq_full};

endmodule

// File: tb/tb_zeroheti_dbg_sba_bridge.sv
// Self-checking bench for zeroheti_dbg_sba_bridge: directed scenarios plus a
// randomized run against an in-order transaction model.
module tb_zeroheti_dbg_sba_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
`ifdef ZEROHETI_DBG_SBA_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sba_req, sba_gnt, sba_we;
  logic [AW-1:0] sba_addr;
  logic [3:0]    sba_be;
  logic [DW-1:0] sba_wdata;
  logic          sba_rvalid, sba_err, sba_other_err;
  logic [DW-1:0] sba_rdata;
  logic          obi_req, obi_gnt, obi_we;
  logic [AW-1:0] obi_addr;
  logic [3:0]    obi_be;
  logic [DW-1:0] obi_wdata;
  logic [2:0]    obi_aid;
  logic          obi_rvalid, obi_err;
  logic [DW-1:0] obi_rdata;
  logic [2:0]    obi_rid;
  logic          spurious;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  zeroheti_dbg_sba_bridge #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO),
    .TimeoutCycles  (TO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sba_req_i       (sba_req),
    .sba_gnt_o       (sba_gnt),
    .sba_addr_i      (sba_addr),
    .sba_we_i        (sba_we),
    .sba_be_i        (sba_be),
    .sba_wdata_i     (sba_wdata),
    .sba_rvalid_o    (sba_rvalid),
    .sba_rdata_o     (sba_rdata),
    .sba_err_o       (sba_err),
    .sba_other_err_o (sba_other_err),
    .obi_req_o       (obi_req),
    .obi_gnt_i       (obi_gnt),
    .obi_addr_o      (obi_addr),
    .obi_we_o        (obi_we),
    .obi_be_o        (obi_be),
    .obi_wdata_o     (obi_wdata),
    .obi_aid_o       (obi_aid),
    .obi_rvalid_i    (obi_rvalid),
    .obi_rdata_i     (obi_rdata),
    .obi_rid_i       (obi_rid),
    .obi_err_i       (obi_err),
    .spurious_o      (spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sba_req = 0; sba_addr = '0; sba_we = 0; sba_be = '0; sba_wdata = '0;
    obi_gnt = 0; obi_rvalid = 0; obi_rdata = '0; obi_rid = '0; obi_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; sba_req = 1; sba_addr = 32'h1234_5678; obi_rvalid = 1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (sba_gnt !== 1'b0)      begin fails++; $display("FAIL reset_gnt: got %b want 0", sba_gnt); end
    checks++; if (obi_req !== 1'b0)      begin fails++; $display("FAIL reset_obi_req: got %b want 0", obi_req); end
    checks++; if (sba_rvalid !== 1'b0)   begin fails++; $display("FAIL reset_rvalid: got %b want 0", sba_rvalid); end
    checks++; if (sba_rdata !== '0)      begin fails++; $display("FAIL reset_rdata: got %h want 0", sba_rdata); end
    checks++; if ({sba_err, sba_other_err} !== 2'b00) begin fails++; $display("FAIL reset_errs: got %b want 00", {sba_err, sba_other_err}); end
    checks++; if (spurious !== 1'b0)     begin fails++; $display("FAIL reset_spurious: got %b want 0", spurious); end
    checks++; if ({obi_addr, obi_wdata, obi_aid} !== '0) begin fails++; $display("FAIL reset_obi_fields: got %h want 0", {obi_addr, obi_wdata, obi_aid}); end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_read();
    do_reset();
    sba_req = 1; sba_addr = 32'h0000_1000; sba_we = 0; sba_be = 4'hF;
    @(negedge clk);
    checks++; if (sba_gnt !== 1'b1) begin fails++; $display("FAIL read_gnt: got %b want 1", sba_gnt); end
    tick();
    sba_req = 0; obi_gnt = 1;
    @(negedge clk);
    checks++; if (obi_req !== 1'b1) begin fails++; $display("FAIL read_obi_req: got %b want 1", obi_req); end
    checks++; if (obi_addr !== 32'h0000_1000 || obi_we !== 1'b0 || obi_aid !== 3'd0)
      begin fails++; $display("FAIL read_obi_fields: got addr=%h we=%b aid=%0d want 1000/0/0", obi_addr, obi_we, obi_aid); end
    tick();
    obi_gnt = 0;
    @(negedge clk);
    checks++; if (obi_req !== 1'b0) begin fails++; $display("FAIL read_obi_req_drop: got %b want 0", obi_req); end
    tick();
    obi_rvalid = 1; obi_rdata = 32'hCAFE_BABE; obi_rid = 3'd0; obi_err = 0;
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b0) begin fails++; $display("FAIL read_rvalid_early: got %b want 0", sba_rvalid); end
    tick();
    obi_rvalid = 0; obi_rdata = '0;
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b1 || sba_rdata !== 32'hCAFE_BABE)
      begin fails++; $display("FAIL read_resp: got v=%b d=%h want 1/cafebabe", sba_rvalid, sba_rdata); end
    checks++; if ({sba_err, sba_other_err} !== 2'b00) begin fails++; $display("FAIL read_resp_errs: got %b want 00", {sba_err, sba_other_err}); end
    tick();
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b0 || sba_rdata !== '0)
      begin fails++; $display("FAIL read_pulse: got v=%b d=%h want 0/0", sba_rvalid, sba_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    logic [DW-1:0] rd;
    int sent = 0;
    int obi_grants = 0;
    logic g, o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addrs[i] = 32'h2000 + 32'(4 * i);
      datas[i] = $urandom;
    end
    obi_gnt = 1;
    for (int c = 0; c < 10; c++) begin
      sba_req = (sent < 3); sba_we = 1; sba_be = 4'hF;
      sba_addr = addrs[sent % 3]; sba_wdata = datas[sent % 3];
      @(negedge clk);
      g = sba_gnt; o = obi_req;
      if (o) begin
        checks++; if (obi_addr !== addrs[obi_grants] || obi_wdata !== datas[obi_grants] || obi_aid !== 3'(obi_grants))
          begin fails++; $display("FAIL b2b_obi_fields: got %h/%h/%0d want %h/%h/%0d", obi_addr, obi_wdata, obi_aid, addrs[obi_grants], datas[obi_grants], obi_grants); end
      end
      tick();
      if (g) sent++;
      if (o) obi_grants++;
    end
    @(negedge clk);
    checks++; if (obi_grants != 2 || sent != 2) begin fails++; $display("FAIL b2b_counts: got obi=%0d sba=%0d want 2/2", obi_grants, sent); end
    checks++; if (sba_gnt !== 1'b0) begin fails++; $display("FAIL b2b_third_held: got %b want 0", sba_gnt); end
    tick();
    rd = $urandom;
    obi_rvalid = 1; obi_rid = 3'd0; obi_rdata = rd;
    @(negedge clk);
    checks++; if (sba_gnt !== 1'b0) begin fails++; $display("FAIL b2b_gnt_during_rsp: got %b want 0", sba_gnt); end
    tick();
    obi_rvalid = 0;
    @(negedge clk);
    checks++; if (sba_gnt !== 1'b1) begin fails++; $display("FAIL b2b_third_gnt: got %b want 1", sba_gnt); end
    checks++; if (sba_rvalid !== 1'b1 || sba_rdata !== rd || sba_other_err !== 1'b0)
      begin fails++; $display("FAIL b2b_rsp0: got v=%b d=%h o=%b want 1/%h/0", sba_rvalid, sba_rdata, sba_other_err, rd); end
    tick();
    sba_req = 0;
    @(negedge clk);
    checks++; if (obi_req !== 1'b1 || obi_aid !== 3'd2 || obi_addr !== addrs[2] || obi_we !== 1'b1 || obi_wdata !== datas[2])
      begin fails++; $display("FAIL b2b_third_obi: got r=%b aid=%0d a=%h d=%h want 1/2/%h/%h", obi_req, obi_aid, obi_addr, obi_wdata, addrs[2], datas[2]); end
    tick();
    obi_gnt = 0;
    for (int k = 1; k <= 2; k++) begin
      rd = $urandom;
      obi_rvalid = 1; obi_rid = 3'(k); obi_rdata = rd;
      tick();
      obi_rvalid = 0;
      @(negedge clk);
      checks++; if (sba_rvalid !== 1'b1 || sba_rdata !== rd || sba_other_err !== 1'b0)
        begin fails++; $display("FAIL b2b_drain%0d: got v=%b d=%h o=%b want 1/%h/0", k, sba_rvalid, sba_rdata, sba_other_err, rd); end
      tick();
    end
  endtask

  task automatic test_id_mismatch();
    logic [DW-1:0] rd;
    do_reset();
    sba_req = 1; sba_addr = $urandom; sba_we = 0; sba_be = 4'hF;
    tick();
    sba_req = 0; obi_gnt = 1;
    tick();
    obi_gnt = 0;
    rd = $urandom;
    obi_rvalid = 1; obi_rid = 3'd5; obi_rdata = rd; obi_err = 0;
    tick();
    obi_rvalid = 0;
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b1 || sba_other_err !== 1'b1 || sba_err !== 1'b0 || sba_rdata !== rd)
      begin fails++; $display("FAIL id_mismatch: got v=%b o=%b e=%b d=%h want 1/1/0/%h", sba_rvalid, sba_other_err, sba_err, sba_rdata, rd); end
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    obi_rvalid = 1; obi_rid = 3'($urandom); obi_rdata = $urandom;
    tick();
    obi_rvalid = 0;
    @(negedge clk);
    checks++; if (spurious !== 1'b1) begin fails++; $display("FAIL spurious_set: got %b want 1", spurious); end
    checks++; if (sba_rvalid !== 1'b0) begin fails++; $display("FAIL spurious_no_rvalid: got %b want 0", sba_rvalid); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (spurious !== 1'b1) begin fails++; $display("FAIL spurious_sticky: got %b want 1", spurious); end
    rst = 1;
    tick();
    @(negedge clk);
    checks++; if (spurious !== 1'b0) begin fails++; $display("FAIL spurious_clear: got %b want 0", spurious); end
    rst = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sba_req = 1; sba_addr = $urandom; sba_we = 1; sba_be = 4'hF; sba_wdata = $urandom;
    tick();
    sba_req = 0; obi_gnt = 0;
    @(negedge clk);
    checks++; if (obi_req !== 1'b1) begin fails++; $display("FAIL rstmid_issue: got %b want 1", obi_req); end
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    checks++; if (obi_req !== 1'b0) begin fails++; $display("FAIL rstmid_obi_req: got %b want 0", obi_req); end
    rst = 0;
    tick();
    obi_rvalid = 1; obi_rid = 3'd0; obi_rdata = $urandom;
    tick();
    obi_rvalid = 0;
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_no_rvalid: got %b want 0", sba_rvalid); end
    tick();
  endtask

`ifdef ZEROHETI_DBG_SBA_TIMEOUT_EN
  task automatic test_timeout();
    int seen = 0;
    logic o;
    logic [DW-1:0] d;
    do_reset();
    sba_req = 1; sba_addr = $urandom; sba_we = 0; sba_be = 4'hF;
    tick();
    sba_req = 0; obi_gnt = 1;
    tick();
    obi_gnt = 0;
    for (int k = 1; k <= 30 && seen == 0; k++) begin
      @(negedge clk);
      if (sba_rvalid) begin seen = k; o = sba_other_err; d = sba_rdata; end
      tick();
    end
    checks++; if (seen != 16) begin fails++; $display("FAIL timeout_latency: got %0d want 16", seen); end
    if (seen != 0) begin
      checks++; if (o !== 1'b1 || d !== '0) begin fails++; $display("FAIL timeout_resp: got o=%b d=%h want 1/0", o, d); end
      for (int k = seen + 1; k < 20; k++) tick();
    end
    obi_rvalid = 1; obi_rid = 3'd0; obi_rdata = $urandom;
    tick();
    obi_rvalid = 0;
    @(negedge clk);
    checks++; if (sba_rvalid !== 1'b0 || spurious !== 1'b0)
      begin fails++; $display("FAIL timeout_late_drop: got v=%b sp=%b want 0/0", sba_rvalid, spurious); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic          pending = 0, in_issue = 0;
    logic [AW-1:0] c_addr, i_addr;
    logic          c_we, i_we;
    logic [3:0]    c_be, i_be;
    logic [DW-1:0] c_wd, i_wd;
    logic [2:0]    next_aid = 0;
    logic [2:0]    slave_q [$];
    logic [2:0]    hd;
    logic          exp_v = 0, exp_err = 0, exp_oth = 0;
    logic [DW-1:0] exp_rd = '0;
    logic          exp_gnt, nv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1; c_addr = $urandom; c_we = 1'($urandom); c_be = 4'($urandom); c_wd = $urandom;
      end
      sba_req = pending; sba_addr = c_addr; sba_we = c_we; sba_be = c_be; sba_wdata = c_wd;
      obi_gnt = 1'($urandom);
      obi_rdata = $urandom; obi_err = ($urandom_range(0, 3) == 0);
      obi_rvalid = (slave_q.size() > 0) && ($urandom_range(0, 2) == 0);
      obi_rid = 3'($urandom);
      if (obi_rvalid) obi_rid = ($urandom_range(0, 5) == 0) ? (slave_q[0] ^ 3'($urandom_range(1, 7))) : slave_q[0];
      @(negedge clk);
      exp_gnt = pending && !in_issue && (slave_q.size() < MO);
      checks++; if (sba_gnt !== exp_gnt) begin fails++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, sba_gnt, exp_gnt); end
      checks++; if (obi_req !== in_issue) begin fails++; $display("FAIL rnd_obi_req c%0d: got %b want %b", c, obi_req, in_issue); end
      if (in_issue) begin
        checks++; if (obi_addr !== i_addr || obi_we !== i_we || obi_be !== i_be || obi_wdata !== i_wd || obi_aid !== next_aid)
          begin fails++; $display("FAIL rnd_obi_fields c%0d: got %h/%b/%h/%h/%0d want %h/%b/%h/%h/%0d", c, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, i_addr, i_we, i_be, i_wd, next_aid); end
      end
      checks++; if (sba_rvalid !== exp_v) begin fails++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, sba_rvalid, exp_v); end
      checks++; if (sba_rdata !== exp_rd || sba_err !== exp_err || sba_other_err !== exp_oth)
        begin fails++; $display("FAIL rnd_resp c%0d: got %h/%b/%b want %h/%b/%b", c, sba_rdata, sba_err, sba_other_err, exp_rd, exp_err, exp_oth); end
      nv = 0;
      if (obi_rvalid) begin
        hd = slave_q.pop_front();
        nv = 1; exp_rd = obi_rdata; exp_err = obi_err; exp_oth = (obi_rid != hd);
      end
      if (!nv) begin exp_rd = '0; exp_err = 0; exp_oth = 0; end
      exp_v = nv;
      if (in_issue && obi_gnt) begin
        slave_q.push_back(next_aid);
        next_aid = next_aid + 3'd1;
        in_issue = 0;
      end
      if (exp_gnt) begin
        in_issue = 1; pending = 0;
        i_addr = c_addr; i_we = c_we; i_be = c_be; i_wd = c_wd;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_read();
    test_back_to_back();
    test_id_mismatch();
    test_spurious();
    test_reset_mid();
`ifdef ZEROHETI_DBG_SBA_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
